req_ack_arbiter: RTL and testbench

Round-robin arbiter that shares one req/ack resource between N_CLIENTS requesters. The resource protocol is fixed:
- req is a single-cycle pulse.
- Consecutive reqs are at least MIN_GAP cycles apart.
- ack arrives exactly ACK_LATENCY cycles after req.
- ack is never high without a req ACK_LATENCY cycles earlier.

The block sequences client requests onto the resource and routes completions back to the issuing client. It also checks the resource side for protocol violations and keeps issue/ack statistics.

---
 rtl/req_ack_arbiter.sv | 178 +++++++++++++++++
 tb/tb_req_ack_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter that shares one single-outstanding req/ack resource
// among N_CLIENTS requesters. Each transaction is issued as a one-cycle
// res_req pulse. The ack is expected exactly ACK_LATENCY cycles later, and
// the next issue is held off until MIN_GAP cycles have elapsed. Completion,
// or a missing ack, is routed back to the issuing client. Late and spurious
// acks set sticky error flags, and issue/ack totals are counted.
module req_ack_arbiter #(
  parameter int N_CLIENTS   = 4,
  parameter int ACK_LATENCY = 4,
  parameter int MIN_GAP     = 8,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CLIENTS-1:0] cli_req,
  output logic [N_CLIENTS-1:0] cli_gnt,
  output logic [N_CLIENTS-1:0] cli_done,
  output logic                 done_err,
  output logic                 res_req,
  input  logic                 res_ack,
  output logic                 busy,
  output logic                 err_late,
  output logic                 err_spurious,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     issued_count,
  output logic [CNT_W-1:0]     acked_count
);

  localparam int PTR_W = $clog2(N_CLIENTS);
  localparam int TMR_W = $clog2(MIN_GAP + 1);

  // The timer reads 1 in the issue cycle and counts up from there.
  // The ack is therefore due when the timer reads ACK_LATENCY+1.
  localparam logic [TMR_W-1:0] GAP_MAX = TMR_W'(MIN_GAP);
  localparam logic [TMR_W-1:0] ACK_AT  = TMR_W'(ACK_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t               state_q,    state_d;
  logic [TMR_W-1:0]     timer_q,    timer_d;
  logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [PTR_W-1:0]     owner_q,    owner_d;
  logic                 res_req_q,  res_req_d;
  logic [N_CLIENTS-1:0] gnt_q,      gnt_d;
  logic [N_CLIENTS-1:0] done_q,     done_d;
  logic                 done_err_q, done_err_d;
  logic                 busy_q,     busy_d;
  logic                 late_q,     late_d;
  logic                 spur_q,     spur_d;
  logic [CNT_W-1:0]     issued_q,   issued_d;
  logic [CNT_W-1:0]     acked_q,    acked_d;

  logic                 arb_found;
  logic [PTR_W-1:0]     arb_win;
  logic                 late_set;
  logic                 spur_set;

  // Round-robin pick: the first requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    arb_found = 1'b0;
    arb_win   = '0;
    idx       = 0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CLIENTS) idx = idx - N_CLIENTS;
      if (!arb_found && cli_req[idx]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'(idx);
      end
    end
  end

  // Next-state logic for the sequencer, the error flags and the counters.
  always_comb begin
    state_d    = state_q;
    timer_d    = (timer_q == GAP_MAX) ? timer_q : timer_q + TMR_W'(1);
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    res_req_d  = 1'b0;
    gnt_d      = '0;
    done_d     = '0;
    done_err_d = 1'b0;
    issued_d   = issued_q;
    acked_d    = acked_q;
    late_set   = 1'b0;
    spur_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        spur_set = res_ack;
        if (timer_q == GAP_MAX && arb_found) begin
          res_req_d      = 1'b1;
          gnt_d[arb_win] = 1'b1;
          owner_d        = arb_win;
          rr_ptr_d       = (arb_win == PTR_W'(N_CLIENTS - 1)) ? '0 : arb_win + PTR_W'(1);
          issued_d       = issued_q + CNT_W'(1);
          timer_d        = TMR_W'(1);
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timer_q == ACK_AT) begin
          // The one cycle in which the ack is legal.
          done_d[owner_q] = 1'b1;
          done_err_d      = ~res_ack;
          late_set        = ~res_ack;
          if (res_ack) acked_d = acked_q + CNT_W'(1);
          state_d = (timer_d == GAP_MAX) ? S_IDLE : S_GAP;
        end else begin
          spur_set = res_ack;
        end
      end
      S_GAP: begin
        spur_set = res_ack;
        if (timer_d == GAP_MAX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A set in the same cycle as err_clr takes priority over the clear.
    late_d = late_set | (late_q & ~err_clr);
    spur_d = spur_set | (spur_q & ~err_clr);
    busy_d = (state_d != S_IDLE) || (timer_d < GAP_MAX);
  end

  // State and output registers. Reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= GAP_MAX;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      res_req_q  <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      done_err_q <= 1'b0;
      busy_q     <= 1'b0;
      late_q     <= 1'b0;
      spur_q     <= 1'b0;
      issued_q   <= '0;
      acked_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      timer_q    <= timer_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      res_req_q  <= res_req_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      busy_q     <= busy_d;
      late_q     <= late_d;
      spur_q     <= spur_d;
      issued_q   <= issued_d;
      acked_q    <= acked_d;
    end
  end

  assign res_req      = res_req_q;
  assign cli_gnt      = gnt_q;
  assign cli_done     = done_q;
  assign done_err     = done_err_q;
  assign busy         = busy_q;
  assign err_late     = late_q;
  assign err_spurious = spur_q;
  assign issued_count = issued_q;
  assign acked_count  = acked_q;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed bench for req_ack_arbiter. Cycle c starts at the c-th rising edge
// after reset release. Inputs are driven, and outputs sampled, 1 time unit
// after that edge. A second instance with 2-bit counters shares the same
// stimulus so that counter wrap can be observed.
module tb_req_ack_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cli_req = '0;
  logic       res_ack = 1'b0;
  logic       err_clr = 1'b0;

  logic [3:0] cli_gnt, cli_done;
  logic       done_err, res_req, busy, err_late, err_spurious;
  logic [7:0] issued_count, acked_count;

  logic [3:0] w_gnt, w_done;
  logic       w_done_err, w_res_req, w_busy, w_late, w_spur;
  logic [1:0] w_issued, w_acked;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int k;

  always #5 clk = ~clk;

  req_ack_arbiter #(.N_CLIENTS(4), .ACK_LATENCY(4), .MIN_GAP(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_gnt(cli_gnt),
    .cli_done(cli_done), .done_err(done_err), .res_req(res_req),
    .res_ack(res_ack), .busy(busy), .err_late(err_late),
    .err_spurious(err_spurious), .err_clr(err_clr),
    .issued_count(issued_count), .acked_count(acked_count)
  );

  req_ack_arbiter #(.N_CLIENTS(4), .ACK_LATENCY(4), .MIN_GAP(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_gnt(w_gnt),
    .cli_done(w_done), .done_err(w_done_err), .res_req(w_res_req),
    .res_ack(res_ack), .busy(w_busy), .err_late(w_late),
    .err_spurious(w_spur), .err_clr(err_clr),
    .issued_count(w_issued), .acked_count(w_acked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset for two edges, then release just after an edge: that is cycle 0.
  task automatic start();
    cli_req = '0;
    res_ack = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // ---------------- Reset state ----------------
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_req", res_req, 0);
    check("rst_gnt", cli_gnt, 0);
    check("rst_done", cli_done, 0);
    check("rst_done_err", done_err, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_late, err_spurious}, 0);
    check("rst_counts", {issued_count, acked_count}, 0);

    // ---------------- Single client ----------------
    start();
    cli_req = 4'b0100;
    next();                                   // cycle 1
    check("single_res_req", res_req, 1);
    check("single_gnt", cli_gnt, 4'b0100);
    check("single_busy", busy, 1);
    cli_req = '0;
    repeat (4) next();                        // cycle 5
    check("single_no_early_done", cli_done, 0);
    res_ack = 1'b1;
    next();                                   // cycle 6
    res_ack = 1'b0;
    check("single_done", cli_done, 4'b0100);
    check("single_done_err", done_err, 0);
    check("single_issued", issued_count, 1);
    check("single_acked", acked_count, 1);
    check("single_errs", {err_late, err_spurious}, 0);

    // ---------------- All four requesting, round robin ----------------
    start();
    cli_req = 4'b1111;
    for (int c = 1; c <= 38; c++) begin
      next();
      res_ack = (cyc % 8 == 5);
      k = (cyc - 1) / 8;
      if (cyc % 8 == 1) begin
        check($sformatf("rr_res_req_c%0d", cyc), res_req, 1);
        check($sformatf("rr_gnt_c%0d", cyc), cli_gnt, 32'(1) << (k % 4));
      end
      if (cyc % 8 == 6) begin
        check($sformatf("rr_done_c%0d", cyc), cli_done, 32'(1) << (k % 4));
        check($sformatf("rr_done_err_c%0d", cyc), done_err, 0);
      end
      if (cyc % 8 == 7) check($sformatf("rr_busy_c%0d", cyc), busy, 1);
      if (cyc % 8 == 0) begin
        check($sformatf("rr_idle_c%0d", cyc), res_req, 0);
        check($sformatf("rr_not_busy_c%0d", cyc), busy, 0);
      end
    end
    res_ack = 1'b0;
    check("rr_issued", issued_count, 5);
    check("rr_acked", acked_count, 5);
    check("rr_errs", {err_late, err_spurious}, 0);
    check("wrap_issued", w_issued, 1);
    check("wrap_acked", w_acked, 1);

    // ---------------- Missing ack ----------------
    start();
    cli_req = 4'b0001;
    next();                                   // cycle 1
    check("late_gnt", cli_gnt, 4'b0001);
    cli_req = '0;
    repeat (5) next();                        // cycle 6
    check("late_done", cli_done, 4'b0001);
    check("late_done_err", done_err, 1);
    check("late_err_late", err_late, 1);
    check("late_acked", acked_count, 0);
    cli_req = 4'b0010;
    next();                                   // cycle 7
    check("late_hold_c7", res_req, 0);
    next();                                   // cycle 8
    check("late_hold_c8", res_req, 0);
    next();                                   // cycle 9
    check("late_reissue", res_req, 1);
    check("late_reissue_gnt", cli_gnt, 4'b0010);
    check("late_sticky", err_late, 1);
    cli_req = '0;
    next();                                   // cycle 10
    err_clr = 1'b1;
    next();                                   // cycle 11
    err_clr = 1'b0;
    check("late_cleared", err_late, 0);

    // ---------------- Spurious ack ----------------
    start();
    repeat (3) next();                        // cycle 3
    res_ack = 1'b1;
    next();                                   // cycle 4
    res_ack = 1'b0;
    check("spur_set", err_spurious, 1);
    check("spur_no_late", err_late, 0);
    check("spur_no_ack_count", acked_count, 0);
    check("spur_no_done", cli_done, 0);
    repeat (6) next();                        // cycle 10
    err_clr = 1'b1;
    next();                                   // cycle 11
    err_clr = 1'b0;
    check("spur_cleared", err_spurious, 0);
    next();                                   // cycle 12
    err_clr = 1'b1;
    res_ack = 1'b1;
    next();                                   // cycle 13
    err_clr = 1'b0;
    res_ack = 1'b0;
    check("spur_set_wins", err_spurious, 1);

    // ---------------- Ack held past its valid cycle ----------------
    start();
    cli_req = 4'b1000;
    next();                                   // cycle 1
    check("hold_gnt", cli_gnt, 4'b1000);
    cli_req = '0;
    repeat (4) next();                        // cycle 5
    res_ack = 1'b1;
    next();                                   // cycle 6
    check("hold_done", cli_done, 4'b1000);
    check("hold_done_err", done_err, 0);
    check("hold_acked", acked_count, 1);
    check("hold_no_spur_yet", err_spurious, 0);
    next();                                   // cycle 7
    res_ack = 1'b0;
    check("hold_spur", err_spurious, 1);
    check("hold_no_late", err_late, 0);

    // ---------------- Reset mid-transaction ----------------
    start();
    cli_req = 4'b0001;
    next();                                   // cycle 1
    check("midrst_issue", res_req, 1);
    cli_req = '0;
    repeat (2) next();                        // cycle 3
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_issued", issued_count, 0);
    check("midrst_outputs", {res_req, cli_gnt, cli_done, done_err}, 0);
    next();                                   // cycle 4
    rst_n = 1'b1;
    next();                                   // cycle 5
    check("midrst_no_done_c5", cli_done, 0);
    res_ack = 1'b1;
    next();                                   // cycle 6
    res_ack = 1'b0;
    check("midrst_no_done_c6", cli_done, 0);
    check("midrst_spur", err_spurious, 1);
    cli_req = 4'b1001;
    next();                                   // cycle 7
    cli_req = '0;
    check("midrst_reissue", res_req, 1);
    check("midrst_ptr_reset", cli_gnt, 4'b0001);
    check("midrst_issued_after", issued_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
